// File: rtl/iterative_divider_if.sv
// Request/response channel between the execute stage and the iterative divider.
// No state of its own; master = core side, slave = divide unit.
// Each direction uses valid/ready; payload must be stable while valid is high.
interface iterative_divider_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [1:0]      op;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, src1, src2, op, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, src1, src2, op, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/iterative_divider.sv
// RV32M DIV/DIVU/REM/REMU unit: restoring radix-2, one quotient bit per cycle.
// Latency: out_valid XLEN+2 cycles after accept (1 cycle for div-by-zero / signed overflow).
// Backpressure: result held in DONE until out_ready; no new request accepted until back in IDLE.
module iterative_divider #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    output logic                busy,
    iterative_divider_if.slave  dif
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvd_q, dvd_d;    // dividend shifts out as quotient bits shift in
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            sgn_op, s1_neg, s2_neg, div_zero, ovf;
    logic [XLEN-1:0] abs1, abs2, quo_fix, rem_fix;
    logic [XLEN:0]   rem_sh, diff;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;

        sgn_op   = !dif.op[0];
        s1_neg   = sgn_op && dif.src1[XLEN-1];
        s2_neg   = sgn_op && dif.src2[XLEN-1];
        abs1     = s1_neg ? -dif.src1 : dif.src1;
        abs2     = s2_neg ? -dif.src2 : dif.src2;
        div_zero = (dif.src2 == '0);
        ovf      = sgn_op && (dif.src1 == INT_MIN) && (dif.src2 == '1);

        rem_sh   = {rem_q, dvd_q[XLEN-1]};
        diff     = rem_sh - {1'b0, dvs_q};
        quo_fix  = neg_q_q ? -dvd_q : dvd_q;
        rem_fix  = neg_r_q ? -rem_q : rem_q;

        case (state_q)
            IDLE: begin
                if (dif.in_valid) begin
                    op_d    = dif.op;
                    neg_q_d = s1_neg ^ s2_neg;
                    neg_r_d = s1_neg;
                    if (div_zero) begin
                        result_d = dif.op[1] ? dif.src1 : '1;
                        state_d  = DONE;
                    end else if (ovf) begin
                        result_d = dif.op[1] ? '0 : INT_MIN;
                        state_d  = DONE;
                    end else begin
                        rem_d   = '0;
                        dvd_d   = abs1;
                        dvs_d   = abs2;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // diff[XLEN] is the borrow of the trial subtract
                if (!diff[XLEN]) begin
                    rem_d = diff[XLEN-1:0];
                    dvd_d = {dvd_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[XLEN-1:0];
                    dvd_d = {dvd_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                result_d = op_q[1] ? rem_fix : quo_fix;
                state_d  = DONE;
            end
            DONE: begin
                if (dif.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
        end
    end

    assign dif.in_ready  = (state_q == IDLE);
    assign dif.out_valid = (state_q == DONE);
    assign dif.result    = result_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_iterative_divider.sv
// Directed plus random checks of iterative_divider against a 64-bit arithmetic reference.
module tb_iterative_divider;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic busy;

    iterative_divider_if #(.XLEN(32)) bus ();

    iterative_divider #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .dif   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: RV32M semantics via 64-bit arithmetic; overflow case falls out naturally.
    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Presents a request and returns just after the edge that accepts it.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op   = o;
        bus.src1 = a;
        bus.src2 = b;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Counts cycles from accept until out_valid is seen (1 = the cycle right after accept).
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 100);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int lat;
        start_op(o, a, b);
        wait_valid(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(ref_lat(o, a, b)));
        chk({tag, "_res"}, bus.result, ref_res(o, a, b));
        @(negedge clk);
        chk({tag, "_idle"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] held, a, b;
        logic [1:0]  o;

        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.op        = 2'b00;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result",    bus.result, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // Directed arithmetic cases
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
        chk("divu_100_7_val", bus.result, 32'd14);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
        chk("remu_100_7_val", bus.result, 32'd2);
        run_op("div_m7_2",   2'b00, -32'sd7, 32'd2);
        chk("div_m7_2_val", bus.result, 32'hFFFF_FFFD);
        run_op("rem_m7_2",   2'b10, -32'sd7, 32'd2);
        chk("rem_m7_2_val", bus.result, 32'hFFFF_FFFF);
        run_op("rem_7_m2",   2'b10, 32'd7, -32'sd2);
        chk("rem_7_m2_val", bus.result, 32'd1);
        run_op("divu_5_0",   2'b01, 32'd5, 32'd0);
        chk("divu_5_0_val", bus.result, 32'hFFFF_FFFF);
        run_op("rem_5_0",    2'b10, 32'd5, 32'd0);
        chk("rem_5_0_val", bus.result, 32'd5);
        run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_val", bus.result, 32'h8000_0000);
        run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("rem_ovf_val", bus.result, 32'd0);
        run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1);

        // Backpressure: result and handshake frozen while out_ready is low
        bus.out_ready = 1'b0;
        start_op(2'b01, 32'd1000, 32'd9);
        wait_valid(lat);
        chk("bp_lat", 32'(lat), 32'd34);
        held = bus.result;
        chk("bp_res", held, 32'd111);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_res",   bus.result, held);
            chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);

        // Flush mid-RUN discards the operation
        start_op(2'b01, 32'd12345, 32'd17);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) lat++;
        end
        chk("flush_no_valid", 32'(lat), 32'd0);
        run_op("post_flush", 2'b01, 32'd9, 32'd3);
        chk("post_flush_val", bus.result, 32'd3);

        // Reset mid-RUN
        start_op(2'b00, 32'd777, 32'd5);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_valid",  {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        chk("midrst_ready",  {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 2'b10, -32'sd100, 32'd7);

        // Random operations
        for (int i = 0; i < 1000; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 99) < 5) b = 32'd0;
            if ($urandom_range(0, 199) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            run_op("rand", o, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
